seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL be parameterised by WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port ctrl_reset, input, 1: asynchronous, active-high reset.
REQ-005 Port ctrl_DIV, input, 1: start pulse; operands SHALL be captured on the clk edge where it is high.
REQ-006 Port data_operandA, input, WIDTH: signed dividend.
REQ-007 Port data_operandB, input, WIDTH: signed divisor.
REQ-008 Port data_result, output, WIDTH: signed quotient.
REQ-009 Port data_remainder, output, WIDTH: signed remainder.
REQ-010 Port data_resultRDY, output, 1: single-cycle strobe marking data_result and data_remainder as valid; downstream SHALL use it as the write enable of its 32-bit result register.
REQ-011 Port data_exception, output, 1: divide-by-zero flag, qualified by data_resultRDY.

Function
REQ-012 The block SHALL have the states IDLE, RUN and DONE.
REQ-013 Transitions:
- IDLE -> RUN on ctrl_DIV with a nonzero divisor.
- IDLE -> DONE on ctrl_DIV with a zero divisor.
- RUN -> DONE after WIDTH iterations.
- DONE -> IDLE after one cycle unless ctrl_DIV is high.
REQ-014 Algorithm: radix-2 restoring division on magnitudes, one quotient bit per cycle; the iteration counter SHALL be clog2(WIDTH)+1 bits wide.
REQ-015 Timing: with ctrl_DIV high at edge 0, data_resultRDY SHALL be high for exactly the cycle following edge WIDTH+1 (33 for WIDTH=32).
REQ-016 Rounding: the quotient SHALL truncate toward zero.
REQ-017 Remainder sign: the remainder sign SHALL equal the dividend sign, with A = Q*B + R exactly.
REQ-018 Divide by zero: data_resultRDY SHALL assert one cycle after capture, with data_exception=1, data_result=0 and data_remainder=0.
REQ-019 Overflow: -2^(WIDTH-1) / -1 SHALL return quotient 0x80000000 (wrapped), remainder 0 and data_exception=0.
REQ-020 Restart: ctrl_DIV high while in RUN or DONE SHALL abandon the current operation, recapture the operands and restart the timing of REQ-015; no data_resultRDY SHALL issue for the abandoned operation.
REQ-021 Hold: data_result and data_remainder SHALL hold their last values while IDLE; data_exception SHALL be 0 whenever data_resultRDY is 0.
REQ-022 Operand stability: operand changes after the capture edge SHALL NOT affect the result.

Reset
REQ-023 Asserting ctrl_reset SHALL immediately force state IDLE, counter 0, data_result 0, data_remainder 0, data_resultRDY 0 and data_exception 0, including mid-RUN.
REQ-024 ctrl_DIV seen on the first edge after reset release SHALL be accepted normally.

Structure
REQ-025 Shared package div_pkg SHALL hold:
- the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
- the WIDTH default;
- the iteration-count constant.
REQ-026 The quotient and remainder output holding stages SHALL each be an instance of the team's existing 32-bit enable register, with enable tied to the DONE entry condition and clear tied to ctrl_reset.
REQ-027 No other sub-module SHALL be used; the shift/subtract datapath SHALL be written inline.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- 100 / 7 -> data_result=14, data_remainder=2, data_resultRDY high exactly on cycle 33, data_exception=0.
- -100 / 7 -> data_result=-14, data_remainder=-2; 100 / -7 -> data_result=-14, data_remainder=2.
- 5 / 0 -> data_resultRDY on cycle 1, data_exception=1, data_result=0, data_remainder=0.
- 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, data_remainder=0, data_exception=0.
- Start 100/7, reassert ctrl_DIV with 9/2 at cycle 10 -> a single data_resultRDY at cycle 43 with data_result=4, data_remainder=1.
- Assert ctrl_reset at cycle 20 of a run -> all outputs 0 at once, no data_resultRDY after release, and the next division completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared constants and state encoding for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  // Default operand / result width in bits.
  localparam int DIV_WIDTH = 32;

  // Shift/subtract iterations per division at the default width (one quotient bit each).
  localparam int DIV_ITER = DIV_WIDTH;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/seq_divider_reg.sv
// seq_divider_reg: enable register with asynchronous active-high clear.
// Latency: 1 cycle from i_en to o_q; clear acts immediately.
// Backpressure: none; o_q holds while i_en is low.
module seq_divider_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Load on enable, hold otherwise, clear asynchronously.
  always_ff @(posedge clk or posedge i_clr) begin
    if (i_clr) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: signed radix-2 restoring divider; quotient truncates toward zero, remainder takes the dividend sign.
// Latency: start at edge 0 -> data_resultRDY high after edge WIDTH+1; divide-by-zero reports after edge 1.
// Backpressure: none; a new ctrl_DIV abandons the operation in flight and restarts from the new operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             ctrl_reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_resultRDY,
  output logic             data_exception
);

  // The package count covers the default build; other widths still iterate once per bit.
  localparam int ITER  = (WIDTH == DIV_WIDTH) ? DIV_ITER : WIDTH;
  localparam int CNT_W = $clog2(ITER) + 1;

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;     // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_rem;     // partial remainder magnitude
  logic [WIDTH-1:0] r_dvs;     // divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_rdy;
  logic             r_exc;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_q_d;
  logic [WIDTH-1:0] w_r_d;
  logic             w_last;
  logic             w_done_entry;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  assign w_a_mag  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_b_zero = (data_operandB == '0);

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  // The partial remainder stays below the divisor, so WIDTH+1 bits hold the borrow cleanly.
  assign w_sh      = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_sh - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // Sign restoration; the -2^(WIDTH-1) / -1 case wraps naturally to 2^(WIDTH-1).
  assign w_q_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // DONE is entered either by the final iteration or by a start with a zero divisor.
  // A start always wins over the final iteration, so an abandoned run never loads.
  assign w_last       = (r_state == ST_RUN) && (r_cnt == CNT_W'(ITER - 1));
  assign w_done_entry = ctrl_DIV ? w_b_zero : w_last;
  assign w_q_d        = ctrl_DIV ? '0 : w_q_fix;
  assign w_r_d        = ctrl_DIV ? '0 : w_r_fix;

  // Controller and datapath: capture on any start, iterate in RUN, strobe on leaving DONE.
  always_ff @(posedge clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_rdy   <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_exc <= 1'b0;
      if (ctrl_DIV) begin
        r_quo   <= w_a_mag;
        r_rem   <= '0;
        r_dvs   <= w_b_mag;
        r_neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_neg_r <= data_operandA[WIDTH-1];
        r_dz    <= w_b_zero;
        r_cnt   <= '0;
        r_state <= w_b_zero ? ST_DONE : ST_RUN;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_RUN: begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_rdy   <= 1'b1;
            r_exc   <= r_dz;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  seq_divider_reg #(.W(WIDTH)) u_quo_reg (
    .clk   (clk),
    .i_clr (ctrl_reset),
    .i_en  (w_done_entry),
    .i_d   (w_q_d),
    .o_q   (data_result)
  );

  seq_divider_reg #(.W(WIDTH)) u_rem_reg (
    .clk   (clk),
    .i_clr (ctrl_reset),
    .i_en  (w_done_entry),
    .i_d   (w_r_d),
    .o_q   (data_remainder)
  );

  assign data_resultRDY = r_rdy;
  assign data_exception = r_exc;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic reference model.
// Latency: expects the strobe WIDTH+1 edges after a start (1 edge for a zero divisor).
// Backpressure: n/a.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         ctrl_reset;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_resultRDY;
  logic         data_exception;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk            (clk),
    .ctrl_reset     (ctrl_reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer division at 64 bits, truncated back to W bits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic exc, output int lat);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q   = '0;
      r   = '0;
      exc = 1'b1;
      lat = 1;
    end else begin
      q   = W'(sa / sb);
      r   = W'(sa % sb);
      exc = 1'b0;
      lat = W + 1;
    end
  endtask

  // Start pulse: operands valid on one edge only, then scrambled to prove they were captured.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Edges until the strobe is seen (1-based), or -1 if the budget expires.
  task automatic wait_rdy(input int budget, output int cyc);
    int i;
    cyc = -1;
    i   = 0;
    while (cyc < 0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
      if (data_resultRDY) cyc = i;
    end
  endtask

  task automatic finish_check(input string tag, input int lat_exp, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic exc);
    int cyc;
    wait_rdy(lat_exp + 8, cyc);
    chk({tag, " latency"}, cyc, lat_exp);
    chk({tag, " quotient"}, data_result, q);
    chk({tag, " remainder"}, data_remainder, r);
    chk({tag, " exception"}, data_exception, exc);
    @(posedge clk);
    #1;
    chk({tag, " strobe width"}, data_resultRDY, 1'b0);
    chk({tag, " exc unqualified"}, data_exception, 1'b0);
    chk({tag, " quotient hold"}, data_result, q);
    chk({tag, " remainder hold"}, data_remainder, r);
  endtask

  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         exc;
    int           lat;
    model(a, b, q, r, exc, lat);
    launch(a, b);
    finish_check(tag, lat, q, r, exc);
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] eq;
  logic [W-1:0] er;
  logic         eexc;
  int           elat;
  int           cyc;
  logic         seen;

  initial begin
    ctrl_reset    = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset quotient", data_result, '0);
    chk("reset remainder", data_remainder, '0);
    chk("reset rdy", data_resultRDY, 1'b0);
    chk("reset exception", data_exception, 1'b0);

    // Start presented on the very first edge after release: 100 / 7.
    model(32'd100, 32'd7, eq, er, eexc, elat);
    @(negedge clk);
    ctrl_reset    = 1'b0;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(posedge clk);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    finish_check("100/7", elat, eq, er, eexc);
    chk("100/7 literal q", data_result, 32'd14);
    chk("100/7 literal r", data_remainder, 32'd2);

    do_div("-100/7", 32'hFFFF_FF9C, 32'd7);
    chk("-100/7 literal q", data_result, 32'hFFFF_FFF2);
    chk("-100/7 literal r", data_remainder, 32'hFFFF_FFFE);
    do_div("100/-7", 32'd100, 32'hFFFF_FFF9);
    chk("100/-7 literal r", data_remainder, 32'd2);
    do_div("5/0", 32'd5, 32'd0);
    do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("min/-1 literal q", data_result, 32'h8000_0000);
    do_div("0/3", 32'd0, 32'd3);
    do_div("max/1", 32'h7FFF_FFFF, 32'd1);

    // Restart mid-run: 100/7 abandoned at edge 10 by 9/2.
    launch(32'd100, 32'd7);
    seen = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (data_resultRDY) seen = 1'b1;
    end
    chk("restart early rdy", seen, 1'b0);
    model(32'd9, 32'd2, eq, er, eexc, elat);
    launch(32'd9, 32'd2);
    wait_rdy(W + 20, cyc);
    chk("restart latency", (cyc < 0) ? cyc : cyc + 10, 10 + W + 1);
    chk("restart quotient", data_result, eq);
    chk("restart remainder", data_remainder, er);
    wait_rdy(40, cyc);
    chk("restart second rdy", cyc, -1);

    // Reset at cycle 20 of a run: outputs clear at once, abandoned op never reports.
    launch(32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #2;
    ctrl_reset = 1'b1;
    #1;
    chk("midrun reset quotient", data_result, '0);
    chk("midrun reset remainder", data_remainder, '0);
    chk("midrun reset rdy", data_resultRDY, 1'b0);
    chk("midrun reset exception", data_exception, 1'b0);
    @(negedge clk);
    @(negedge clk);
    ctrl_reset = 1'b0;
    wait_rdy(45, cyc);
    chk("post reset stray rdy", cyc, -1);
    do_div("after reset", 32'd1000, 32'd3);

    // Randomized operands across magnitude classes.
    for (int k = 0; k < 50; k++) begin
      case ($urandom_range(0, 4))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = W'($urandom_range(1, 15)); if ($urandom_range(0, 1) == 1) rb = -rb; end
        2: begin ra = W'($urandom_range(0, 200)) - W'(100); rb = W'($urandom_range(0, 20)) - W'(10); end
        3: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
        default: begin ra = $urandom; rb = '0; end
      endcase
      do_div($sformatf("rnd%0d", k), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
